itcm_uart_loader: RTL and testbench
===================================

Name: itcm_uart_loader

Overview:
Boot-time loader on the instruction side of soc_top. Receives a program image over a UART RX line and assembles it into 32-bit little-endian words. Writes each word into the ITCM write port. Asserts cpu_en once the image is fully written, so the CPU starts fetching only after the ITCM holds valid instructions.

Parameters:
CLK_FREQ, 50000000, CLK_IN frequency in Hz.
BAUD, 115200, UART bit rate.
ADDR_WIDTH, 13, ITCM word-address width (8192 words).
CLKS_PER_BIT, CLK_FREQ/BAUD (434), clocks per UART bit; derived, not overridden.

Ports:
CLK_IN  input  1  system clock; all logic on the rising edge.
RST_N  input  1  reset; synchronous, active-low.
RX  input  1  UART receive line; idle high; 8N1, LSB first.
itcm_we  output  1  ITCM write strobe, one-cycle pulse per word.
itcm_waddr  output  ADDR_WIDTH  ITCM word address.
itcm_wdata  output  32  ITCM write data.
cpu_en  output  1  CPU enable; sticky high after a successful load.
load_busy  output  1  high from the first received byte until DONE or ERR.
load_err  output  1  sticky error flag.

Behaviour:
- Reset (RST_N low at an edge): all outputs 0. Both FSMs return to IDLE / L_LEN0. Byte, word and count registers clear. Any partial word is discarded.
- RX input path: 2-flop synchronizer, reset value 1. All decisions use the synchronized value.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synchronized RX = 0, go to START with the bit counter cleared.
  - START: at CLKS_PER_BIT/2 (217) re-sample RX. If 0, go to DATA. If 1 (glitch), return to IDLE.
  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
  - STOP: after one more CLKS_PER_BIT, sample RX.
    - RX = 1: a byte_valid pulse is issued for one cycle, then return to IDLE.
    - RX = 0: framing error; the loader goes to L_ERR.
- Loader FSM states: L_LEN0, L_LEN1, L_DATA, L_CSUM (macro only), L_DONE, L_ERR.
  - L_LEN0 / L_LEN1: capture word count N, low byte first (16 bits).
  - At end of L_LEN1:
    - N = 0: go to L_DONE.
    - N > 2^ADDR_WIDTH: go to L_ERR.
    - Otherwise go to L_DATA, with word index 0 and byte lane 0.
  - L_DATA: each byte fills a lane; byte0 goes to [7:0], byte3 to [31:24].
  - On the 4th byte_valid of a word:
    - the next cycle drives itcm_we = 1, with itcm_waddr = word index and itcm_wdata = assembled word;
    - the word index increments and the lane resets to 0.
  - After write N-1: go to L_CSUM if the macro is defined, else to L_DONE.
- cpu_en rises in the cycle after entry to L_DONE (registered) and stays high until reset. load_busy falls in that same cycle.
- L_DONE and L_ERR are absorbing: further RX traffic is received but ignored, with no writes and no flag changes.
- L_ERR: load_err = 1, cpu_en stays 0, load_busy = 0.
- itcm_waddr and itcm_wdata hold their last value when itcm_we = 0.
- A write never overlaps a byte_valid: at most one write per 4 bytes, and bytes arrive at least 10*CLKS_PER_BIT clocks apart.
- The word index never wraps: the N bound guarantees the last address is N-1 ≤ 2^ADDR_WIDTH - 1.

Optional Feature:
Macro: ITCM_LOADER_CHECKSUM_EN.
- Defined:
  - One extra trailing byte follows the image.
  - An 8-bit running sum (mod 256) covers every image data byte; the two length bytes are excluded.
  - Trailing byte equals the sum: go to L_DONE.
  - Trailing byte differs: go to L_ERR.
- Not defined: no trailing byte is expected. The L_CSUM state and the sum register are not built, and L_DATA goes directly to L_DONE.

Test Plan:
- Send N = 0x0002, then words 0x00000093 and 0x00100113 (bytes 93 00 00 00 13 01 10 00), with the macro off:
  - writes at addr 0 and addr 1 with exactly those data;
  - cpu_en rises 1 cycle after entry to L_DONE; load_err = 0.
- Send N = 0x0000: no itcm_we; cpu_en = 1 after the second length byte; load_busy returns to 0.
- Send N = 0x2001 (8193 > 8192): load_err = 1, no writes, cpu_en stays 0. Subsequent bytes cause no writes.
- Drive RX low for 100 cycles, then high (a glitch shorter than a half bit): no byte_valid. A following valid frame 0x01 0x00 is accepted as N = 1.
- Send a byte with its stop bit held low: load_err = 1 and cpu_en = 0.
- Assert RST_N = 0 for 1 cycle after 2 of 4 data bytes:
  - all outputs go to 0;
  - a fresh load of N = 1, word 0xDEADBEEF, writes addr 0 = 0xDEADBEEF with no stale bytes;
  - with ITCM_LOADER_CHECKSUM_EN defined, trailing byte 0x38 gives cpu_en = 1, and trailing byte 0x39 gives load_err = 1.

Source files
------------

// File: rtl/itcm_uart_loader.sv
// UART boot loader: receives a length-prefixed image (8N1, LSB first) and writes it into ITCM
// as little-endian words, then raises cpu_en. ITCM_LOADER_CHECKSUM_EN adds a trailing sum byte.
module itcm_uart_loader #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  CLK_IN,
    input  logic                  RST_N,
    input  logic                  RX,
    output logic                  itcm_we,
    output logic [ADDR_WIDTH-1:0] itcm_waddr,
    output logic [31:0]           itcm_wdata,
    output logic                  cpu_en,
    output logic                  load_busy,
    output logic                  load_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    typedef enum logic [2:0] {
        L_LEN0,
        L_LEN1,
        L_DATA,
`ifdef ITCM_LOADER_CHECKSUM_EN
        L_CSUM,
`endif
        L_DONE,
        L_ERR
    } ld_state_t;

    // ------------------------------------------------------------------ receiver
    logic             rx_meta, rx_sync;
    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       rx_byte, rx_byte_nxt;
    logic             byte_valid, byte_valid_nxt;
    logic             frame_err, frame_err_nxt;

    // NOTE: reset is synchronous; RST_N is only looked at on the clock edge, so it
    // must be held low across at least one rising edge of CLK_IN.
    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_state   <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rx_meta    <= RX;
            rx_sync    <= rx_meta;
            rx_state   <= rx_state_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            rx_byte    <= rx_byte_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        rx_state_nxt   = rx_state;
        baud_cnt_nxt   = baud_cnt;
        bit_idx_nxt    = bit_idx;
        rx_byte_nxt    = rx_byte;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;

        unique case (rx_state)
            IDLE: begin
                if (!rx_sync) begin
                    rx_state_nxt = START;
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_cnt_nxt = '0;
                    rx_state_nxt = rx_sync ? IDLE : DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_nxt = '0;
                    rx_byte_nxt  = {rx_sync, rx_byte[7:1]};
                    if (bit_idx == 3'd7) rx_state_nxt = STOP;
                    else                 bit_idx_nxt  = bit_idx + 1'b1;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_nxt   = '0;
                    rx_state_nxt   = IDLE;
                    byte_valid_nxt = rx_sync;
                    frame_err_nxt  = !rx_sync;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            default: rx_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------ loader
    ld_state_t             ld_state, ld_state_nxt;
    logic [15:0]           len_cnt, len_cnt_nxt, len_full;
    logic [ADDR_WIDTH-1:0] word_idx, word_idx_nxt;
    logic [1:0]            lane, lane_nxt;
    logic [31:0]           word_buf, word_buf_nxt;
    logic                  we_nxt, cpu_en_nxt, busy_nxt, err_nxt;
    logic [ADDR_WIDTH-1:0] waddr_nxt;
    logic [31:0]           wdata_nxt;
`ifdef ITCM_LOADER_CHECKSUM_EN
    logic [7:0]            csum, csum_nxt;
`endif

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            ld_state   <= L_LEN0;
            len_cnt    <= '0;
            word_idx   <= '0;
            lane       <= '0;
            word_buf   <= '0;
            itcm_we    <= 1'b0;
            itcm_waddr <= '0;
            itcm_wdata <= '0;
            cpu_en     <= 1'b0;
            load_busy  <= 1'b0;
            load_err   <= 1'b0;
`ifdef ITCM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            ld_state   <= ld_state_nxt;
            len_cnt    <= len_cnt_nxt;
            word_idx   <= word_idx_nxt;
            lane       <= lane_nxt;
            word_buf   <= word_buf_nxt;
            itcm_we    <= we_nxt;
            itcm_waddr <= waddr_nxt;
            itcm_wdata <= wdata_nxt;
            cpu_en     <= cpu_en_nxt;
            load_busy  <= busy_nxt;
            load_err   <= err_nxt;
`ifdef ITCM_LOADER_CHECKSUM_EN
            csum       <= csum_nxt;
`endif
        end
    end

    always_comb begin
        ld_state_nxt = ld_state;
        len_cnt_nxt  = len_cnt;
        len_full     = {rx_byte, len_cnt[7:0]};
        word_idx_nxt = word_idx;
        lane_nxt     = lane;
        word_buf_nxt = word_buf;
        we_nxt       = 1'b0;
        waddr_nxt    = itcm_waddr;
        wdata_nxt    = itcm_wdata;
        busy_nxt     = load_busy;
`ifdef ITCM_LOADER_CHECKSUM_EN
        csum_nxt     = csum;
`endif

        unique case (ld_state)
            L_LEN0: begin
                if (byte_valid) begin
                    len_cnt_nxt[7:0] = rx_byte;
                    busy_nxt         = 1'b1;
                    ld_state_nxt     = L_LEN1;
                end
            end
            L_LEN1: begin
                if (byte_valid) begin
                    len_cnt_nxt[15:8] = rx_byte;
                    word_idx_nxt      = '0;
                    lane_nxt          = '0;
                    if (len_full == 16'd0)                  ld_state_nxt = L_DONE;
                    else if ({1'b0, len_full} > MAX_WORDS) ld_state_nxt = L_ERR;
                    else                                    ld_state_nxt = L_DATA;
                end
            end
            L_DATA: begin
                if (byte_valid) begin
                    word_buf_nxt[{lane, 3'b000} +: 8] = rx_byte;
`ifdef ITCM_LOADER_CHECKSUM_EN
                    csum_nxt = csum + rx_byte;
`endif
                    if (lane == 2'd3) begin
                        we_nxt       = 1'b1;
                        waddr_nxt    = word_idx;
                        wdata_nxt    = word_buf_nxt;
                        lane_nxt     = '0;
                        word_idx_nxt = word_idx + 1'b1;
                        if (17'(word_idx) + 17'd1 == {1'b0, len_cnt}) begin
`ifdef ITCM_LOADER_CHECKSUM_EN
                            ld_state_nxt = L_CSUM;
`else
                            ld_state_nxt = L_DONE;
`endif
                        end
                    end else begin
                        lane_nxt = lane + 1'b1;
                    end
                end
            end
`ifdef ITCM_LOADER_CHECKSUM_EN
            L_CSUM: begin
                if (byte_valid) ld_state_nxt = (rx_byte == csum) ? L_DONE : L_ERR;
            end
`endif
            L_DONE, L_ERR: ;
            default: ld_state_nxt = L_ERR;
        endcase

        // A framing error aborts any load still in progress; finished states are absorbing.
        if (frame_err && ld_state != L_DONE && ld_state != L_ERR) ld_state_nxt = L_ERR;

        if (ld_state == L_DONE || ld_state == L_ERR) busy_nxt = 1'b0;
        cpu_en_nxt = cpu_en | (ld_state == L_DONE);
        err_nxt    = load_err | (ld_state == L_ERR);
    end

endmodule

// File: tb/tb_itcm_uart_loader.sv
// Self-checking bench for itcm_uart_loader: a byte-stream model predicts the ITCM writes and
// final flags; a per-cycle compare process checks writes, held outputs and flag transitions.
module tb_itcm_uart_loader;
    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int AW       = 13;
    localparam int CPB      = CLK_FREQ / BAUD;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx    = 1'b1;
    logic          itcm_we;
    logic [AW-1:0] itcm_waddr;
    logic [31:0]   itcm_wdata;
    logic          cpu_en, load_busy, load_err;

    itcm_uart_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_WIDTH(AW)) dut (
        .CLK_IN    (clk),
        .RST_N     (rst_n),
        .RX        (rx),
        .itcm_we   (itcm_we),
        .itcm_waddr(itcm_waddr),
        .itcm_wdata(itcm_wdata),
        .cpu_en    (cpu_en),
        .load_busy (load_busy),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------------------------------------------------------- model
    wr_t     exp_q[$];
    bit      exp_done, exp_err, exp_busy, exp_rise_after_write;
    byte_q_t stim;

    task automatic model_load(input byte_q_t s);
        int n;
        bit complete;
        wr_t e;
`ifdef ITCM_LOADER_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'h00;
`endif
        exp_done = 0;
        exp_err  = 0;
        exp_rise_after_write = 0;
        exp_busy = (s.size() > 0);
        if (s.size() >= 2) begin
            n = int'({s[1], s[0]});
            if (n == 0) begin
                exp_done = 1;
            end else if (n > (1 << AW)) begin
                exp_err = 1;
            end else begin
                complete = 1;
                for (int w = 0; w < n; w++) begin
                    if (2 + 4 * w + 3 >= s.size()) begin
                        complete = 0;
                        break;
                    end
                    e.addr = AW'(w);
                    e.data = {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]};
                    exp_q.push_back(e);
`ifdef ITCM_LOADER_CHECKSUM_EN
                    sum = sum + s[2+4*w] + s[2+4*w+1] + s[2+4*w+2] + s[2+4*w+3];
`endif
                end
`ifdef ITCM_LOADER_CHECKSUM_EN
                if (complete && s.size() > 2 + 4 * n) begin
                    if (s[2+4*n] == sum) exp_done = 1;
                    else                 exp_err  = 1;
                end
`else
                if (complete) begin
                    exp_done = 1;
                    exp_rise_after_write = 1;
                end
`endif
            end
        end
        if (exp_done || exp_err) exp_busy = 0;
    endtask

`ifdef ITCM_LOADER_CHECKSUM_EN
    function automatic logic [7:0] image_sum();
        logic [7:0] s = 8'h00;
        for (int i = 2; i < stim.size(); i++) s = s + stim[i];
        return s;
    endfunction
`endif

    // ---------------------------------------------------------------- compare
    bit            rst_at_edge = 0;
    int            cyc = 0;
    int            last_we_cyc = 0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_data = '0;
    logic          prev_cpu = 1'b0, prev_err = 1'b0;

    always @(posedge clk) begin
        rst_at_edge <= !rst_n;
        cyc         <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_at_edge) begin
            check("reset_we", itcm_we, 0);
            check("reset_waddr", itcm_waddr, 0);
            check("reset_wdata", itcm_wdata, 0);
            check("reset_cpu_en", cpu_en, 0);
            check("reset_busy", load_busy, 0);
            check("reset_err", load_err, 0);
            last_addr = '0;
            last_data = '0;
            prev_cpu  = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (itcm_we) begin
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", itcm_waddr, e.addr);
                    check("write_data", itcm_wdata, e.data);
                    last_addr   = e.addr;
                    last_data   = e.data;
                    last_we_cyc = cyc;
                end
            end else begin
                check("hold_addr", itcm_waddr, last_addr);
                check("hold_data", itcm_wdata, last_data);
            end
            check("cpu_err_exclusive", cpu_en & load_err, 0);
            if (cpu_en && !prev_cpu) begin
                check("cpu_en_rise_expected", exp_done, 1);
                if (exp_rise_after_write)
                    check("cpu_en_latency", (cyc - last_we_cyc) inside {1, 2}, 1);
            end
            if (prev_cpu) check("cpu_en_sticky", cpu_en, 1);
            if (load_err && !prev_err) check("load_err_rise_expected", exp_err, 1);
            if (prev_err) check("load_err_sticky", load_err, 1);
            prev_cpu = cpu_en;
            prev_err = load_err;
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            tick(CPB);
        end
        rx = 1'b1;
        tick(int'($urandom_range(0, 3)));
    endtask

    task automatic send_stream();
        foreach (stim[i]) send_byte(stim[i], 1'b1);
        tick(10);
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stim.push_back(w[8*i +: 8]);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_cpu_en"}, cpu_en, exp_done);
        check({tag, "_load_err"}, load_err, exp_err);
        check({tag, "_load_busy"}, load_busy, exp_busy);
        check({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_busy = 0;
        exp_rise_after_write = 0;
        rx    = 1'b1;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: cycle budget exceeded, cpu_en=%0b load_err=%0b", cpu_en, load_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy", load_busy, 0);

        // Two-word image
        stim = {8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
`ifdef ITCM_LOADER_CHECKSUM_EN
        stim.push_back(8'hB7);
`endif
        model_load(stim);
        check("pin_w0_addr", exp_q[0].addr, 0);
        check("pin_w0_data", exp_q[0].data, 32'h0000_0093);
        check("pin_w1_addr", exp_q[1].addr, 1);
        check("pin_w1_data", exp_q[1].data, 32'h0010_0113);
        send_stream();
        check_flags("two_words");
        stim = {8'h5A, 8'h01, 8'hFF, 8'h00};
        send_stream();
        check_flags("after_done");

        // Empty image
        do_reset();
        stim = {8'h00, 8'h00};
        model_load(stim);
        check("pin_empty_done", exp_done, 1);
        send_stream();
        check_flags("empty");

        // Oversized image, trailing bytes must be ignored
        do_reset();
        stim = {8'h01, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};
        model_load(stim);
        check("pin_oversize_err", exp_err, 1);
        send_stream();
        check_flags("oversize");

        // Largest legal length is accepted and leaves the loader waiting for data
        do_reset();
        stim = {8'h00, 8'h20};
        model_load(stim);
        check("pin_max_busy", exp_busy, 1);
        send_stream();
        check_flags("max_len");

        // Glitch shorter than half a bit, then a one-word image
        do_reset();
        rx = 1'b0;
        tick(CPB / 2 - 6);
        rx = 1'b1;
        tick(2 * CPB);
        check("glitch_busy", load_busy, 0);
        stim = {8'h01, 8'h00};
        add_word($urandom);
`ifdef ITCM_LOADER_CHECKSUM_EN
        stim.push_back(image_sum());
`endif
        model_load(stim);
        send_stream();
        check_flags("after_glitch");

        // Framing error
        do_reset();
        exp_err = 1;
        send_byte(8'h55, 1'b0);
        tick(CPB);
        check_flags("framing");

        // Reset in the middle of a word, then a clean reload
        do_reset();
        stim = {8'h01, 8'h00, 8'hEF, 8'hBE};
        model_load(stim);
        send_stream();
        check_flags("partial");
        do_reset();
        stim = {8'h01, 8'h00};
        add_word(32'hDEAD_BEEF);
`ifdef ITCM_LOADER_CHECKSUM_EN
        stim.push_back(8'h38);
`endif
        model_load(stim);
        check("pin_beef", exp_q[0].data, 32'hDEAD_BEEF);
        send_stream();
        check_flags("reload");
`ifdef ITCM_LOADER_CHECKSUM_EN
        do_reset();
        stim = {8'h01, 8'h00};
        add_word(32'hDEAD_BEEF);
        stim.push_back(8'h39);
        model_load(stim);
        check("pin_bad_csum_err", exp_err, 1);
        send_stream();
        check_flags("bad_csum");
`endif

        // Random images
        for (int t = 0; t < 4; t++) begin
            do_reset();
            n = int'($urandom_range(1, 4));
            stim = {};
            stim.push_back(8'(n));
            stim.push_back(8'h00);
            for (int w = 0; w < n; w++) add_word($urandom);
`ifdef ITCM_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 1) == 0) stim.push_back(image_sum());
            else stim.push_back(image_sum() + 8'($urandom_range(1, 255)));
`endif
            model_load(stim);
            send_stream();
            check_flags("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
